fpu_ss_wb_arbiter: RTL and testbench
====================================

# fpu_ss_wb_arbiter

Write-back arbiter for the FPU subsystem: merges FPU results and memory load results (FLW) onto the single FP register-file write port, and forwards FPU results destined for the integer file (compares, FCLASS, FCVT.W, FMV.X.W) to the core's integer write-back handshake. Load results cannot be back-pressured, so they pass through a small FIFO; a starvation counter bounds how long an FPU result can be held off. Its outputs are the write-back signals that the FPU subsystem trace monitor samples.

## Interface
- `LD_BUF_DEPTH`, 2, load-result FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 4, max consecutive cycles an FPR-bound FPU result may wait before it takes priority
- `clk_i` in 1 clock; all state updates on rising edge
- `rst_ni` in 1 reset, synchronous, active-low
- `fpu_out_valid_i` in 1 FPU result valid
- `fpu_out_ready_o` out 1 FPU result accepted
- `fpu_rd_is_fpr_i` in 1 1 = result targets FPR, 0 = integer file
- `fpu_waddr_i` in 5 destination register
- `fpu_result_i` in 32 result data
- `mem_result_valid_i` in 1 load data return (no ready)
- `mem_waddr_i` in 5 load destination FPR
- `mem_result_i` in 32 load data
- `fpr_we_o` out 1 FPR write enable (registered)
- `fpr_waddr_o` out 5 FPR write address (registered)
- `fpr_wdata_o` out 32 FPR write data (registered)
- `int_wb_valid_o` out 1 integer write-back valid
- `int_wb_ready_i` in 1 core accepts integer write-back
- `int_wb_addr_o` out 5 integer destination
- `int_wb_data_o` out 32 integer data
- `ld_buf_cnt_o` out $clog2(LD_BUF_DEPTH)+1 FIFO occupancy
- `ld_buf_full_o` out 1 occupancy == LD_BUF_DEPTH; issue logic stops issuing loads
- `overflow_o` out 1 sticky error: load arrived with no slot

## Operation
- Integer path, combinational pass-through: `int_wb_valid_o = fpu_out_valid_i & ~fpu_rd_is_fpr_i`; addr/data are the FPU inputs; `fpu_out_ready_o = int_wb_ready_i` when `~fpu_rd_is_fpr_i`.
- FPR path, one write per cycle. `fpu_req = fpu_out_valid_i & fpu_rd_is_fpr_i`.
- `fpu_grant = fpu_req & (starve_cnt == STARVE_LIMIT | (cnt == 0 & ~mem_result_valid_i))`; `fpu_out_ready_o = fpu_grant` when `fpu_rd_is_fpr_i`.
- If not `fpu_grant`: FIFO head written (pop) if cnt>0, else incoming load written directly (bypass, no push).
- Push incoming load when `mem_result_valid_i & (cnt>0 | fpu_grant)`.
- Push allowed if cnt<DEPTH or pop in same cycle. Push with cnt==DEPTH and no pop (only possible under `fpu_grant`): data dropped, `overflow_o` set, cleared only by reset.
- Simultaneous push+pop: cnt unchanged; order preserved (FIFO).
- `starve_cnt`: +1 (saturating at STARVE_LIMIT) when `fpu_req & ~fpu_grant`; 0 on grant or when `~fpu_req`.

## Timing
- FPR write latency: 1 cycle from winning source to `fpr_we_o`; bypassed load appears next cycle; buffered load appears the cycle after its pop.
- Integer path: 0-cycle combinational; valid/addr/data held stable by FPU until ready.
- Reset (synchronous, `rst_ni`=0 at edge): `fpr_we_o`=0, `fpr_waddr_o`=0, `fpr_wdata_o`=0, FIFO pointers/cnt=0, `starve_cnt`=0, `overflow_o`=0; `ld_buf_full_o`=0. Reset mid-operation discards buffered loads.
- Combinational outputs `int_wb_*`, `fpu_out_ready_o` follow inputs regardless of reset state (FPU is itself held in reset).
- Worst-case FPU wait: STARVE_LIMIT cycles after which it wins; loads arriving then are buffered.

## Structure
- Shared package `fpu_ss_pkg`: `fpr_wb_t` struct {addr[4:0], data[31:0]}, `XLEN`=32 constant.
- Sub-module `fpu_ss_wb_fifo` (parametric depth, push/pop/cnt/full/empty) instantiated for the load buffer; arbitration, starvation counter and output registers in top.

## Test plan
- Idle, single FPU `fadd` result addr 3 data 0x3F800000 -> ready same cycle, next cycle `fpr_we_o`=1, addr 3, data 0x3F800000.
- Load (addr 5, 0x40000000) and FPU result (addr 6) same cycle, cnt=0 -> load written next cycle, FPU ready=0; FPU granted following cycle, writes addr 6.
- Load every cycle for 6 cycles with FPU FPR result pending, STARVE_LIMIT=4 -> FPU granted on 5th cycle, that load buffered (cnt=1), drained after; all 7 writes in order, no overflow.
- Two loads buffered (cnt=2, full) + FPU granted + third load arrives -> `overflow_o`=1 sticky, third load not written.
- `feq.s` result (int, addr 10, data 1) with `int_wb_ready_i`=0 for 3 cycles -> `int_wb_valid_o` held, `fpu_out_ready_o`=0; ready rises -> handshake same cycle, no FPR write.
- Reset asserted with cnt=2 -> next cycle cnt=0, `fpr_we_o`=0, `overflow_o`=0, buffered data never written.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// Types and constants shared across the FPU subsystem write-back logic.
package fpu_ss_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } fpr_wb_t;

endpackage

// File: rtl/fpu_ss_wb_arbiter_if.sv
// Handshake bundle between the FPU, the load-return path, the core integer
// write-back port and the write-back arbiter.
interface fpu_ss_wb_arbiter_if;
  import fpu_ss_pkg::*;

  logic            fpu_out_valid_i;
  logic            fpu_out_ready_o;
  logic            fpu_rd_is_fpr_i;
  logic [4:0]      fpu_waddr_i;
  logic [XLEN-1:0] fpu_result_i;

  logic            mem_result_valid_i;
  logic [4:0]      mem_waddr_i;
  logic [XLEN-1:0] mem_result_i;

  logic            int_wb_valid_o;
  logic            int_wb_ready_i;
  logic [4:0]      int_wb_addr_o;
  logic [XLEN-1:0] int_wb_data_o;

  // Driven by the FPU / memory / core side.
  modport master (
    output fpu_out_valid_i, fpu_rd_is_fpr_i, fpu_waddr_i, fpu_result_i,
    output mem_result_valid_i, mem_waddr_i, mem_result_i, int_wb_ready_i,
    input  fpu_out_ready_o, int_wb_valid_o, int_wb_addr_o, int_wb_data_o
  );

  // Seen by the arbiter.
  modport slave (
    input  fpu_out_valid_i, fpu_rd_is_fpr_i, fpu_waddr_i, fpu_result_i,
    input  mem_result_valid_i, mem_waddr_i, mem_result_i, int_wb_ready_i,
    output fpu_out_ready_o, int_wb_valid_o, int_wb_addr_o, int_wb_data_o
  );

endinterface

// File: rtl/fpu_ss_wb_fifo.sv
// Small load-result FIFO with a combinational head; flags pushes that find no slot.
module fpu_ss_wb_fifo
  import fpu_ss_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  fpr_wb_t                  data_i,
  input  logic                     pop_i,
  output fpr_wb_t                  data_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fpr_wb_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a full-FIFO push lands in.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// Merges FPU and load results onto the single FPR write port and forwards
// integer-destined FPU results to the core write-back handshake.
module fpu_ss_wb_arbiter
  import fpu_ss_pkg::*;
#(
  parameter int LD_BUF_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  fpu_ss_wb_arbiter_if.slave              wb,
  output logic                            fpr_we_o,
  output logic [4:0]                      fpr_waddr_o,
  output logic [XLEN-1:0]                 fpr_wdata_o,
  output logic [$clog2(LD_BUF_DEPTH):0]   ld_buf_cnt_o,
  output logic                            ld_buf_full_o,
  output logic                            overflow_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic            fpr_we_q, fpr_we_d;
  logic [4:0]      fpr_waddr_q, fpr_waddr_d;
  logic [XLEN-1:0] fpr_wdata_q, fpr_wdata_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            overflow_q, overflow_d;

  logic    fpu_req, fpu_grant, starve_hit;
  logic    fifo_push, fifo_pop, fifo_empty, fifo_drop, bypass;
  fpr_wb_t mem_wb, head_wb;

  assign fpu_req    = wb.fpu_out_valid_i & wb.fpu_rd_is_fpr_i;
  assign starve_hit = (starve_cnt_q == SW'(STARVE_LIMIT));
  assign fpu_grant  = fpu_req & (starve_hit | (fifo_empty & ~wb.mem_result_valid_i));

  // Integer results bypass arbitration entirely; the FPU holds them until taken.
  assign wb.int_wb_valid_o  = wb.fpu_out_valid_i & ~wb.fpu_rd_is_fpr_i;
  assign wb.int_wb_addr_o   = wb.fpu_waddr_i;
  assign wb.int_wb_data_o   = wb.fpu_result_i;
  assign wb.fpu_out_ready_o = wb.fpu_rd_is_fpr_i ? fpu_grant : wb.int_wb_ready_i;

  // Buffered loads drain before new ones so write order matches arrival order.
  assign fifo_pop  = ~fpu_grant & ~fifo_empty;
  assign bypass    = ~fpu_grant & fifo_empty & wb.mem_result_valid_i;
  assign fifo_push = wb.mem_result_valid_i & (~fifo_empty | fpu_grant);
  assign mem_wb    = '{addr: wb.mem_waddr_i, data: wb.mem_result_i};

  fpu_ss_wb_fifo #(
    .DEPTH (LD_BUF_DEPTH)
  ) u_ld_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (mem_wb),
    .pop_i   (fifo_pop),
    .data_o  (head_wb),
    .cnt_o   (ld_buf_cnt_o),
    .full_o  (ld_buf_full_o),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  always_comb begin
    fpr_we_d     = 1'b0;
    fpr_waddr_d  = fpr_waddr_q;
    fpr_wdata_d  = fpr_wdata_q;
    starve_cnt_d = '0;
    overflow_d   = overflow_q | fifo_drop;

    if (fpu_grant) begin
      fpr_we_d    = 1'b1;
      fpr_waddr_d = wb.fpu_waddr_i;
      fpr_wdata_d = wb.fpu_result_i;
    end else if (fifo_pop) begin
      fpr_we_d    = 1'b1;
      fpr_waddr_d = head_wb.addr;
      fpr_wdata_d = head_wb.data;
    end else if (bypass) begin
      fpr_we_d    = 1'b1;
      fpr_waddr_d = wb.mem_waddr_i;
      fpr_wdata_d = wb.mem_result_i;
    end

    if (fpu_req & ~fpu_grant)
      starve_cnt_d = starve_hit ? starve_cnt_q : starve_cnt_q + SW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fpr_we_q     <= 1'b0;
      fpr_waddr_q  <= '0;
      fpr_wdata_q  <= '0;
      starve_cnt_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      fpr_we_q     <= fpr_we_d;
      fpr_waddr_q  <= fpr_waddr_d;
      fpr_wdata_q  <= fpr_wdata_d;
      starve_cnt_q <= starve_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign fpr_we_o    = fpr_we_q;
  assign fpr_waddr_o = fpr_waddr_q;
  assign fpr_wdata_o = fpr_wdata_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Directed bench for the FPU write-back arbiter: FPR merging, starvation,
// FIFO overflow, integer handshake and reset.
module tb_fpu_ss_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fpr_we_o;
  logic [4:0]  fpr_waddr_o;
  logic [31:0] fpr_wdata_o;
  logic [1:0]  ld_buf_cnt_o;
  logic        ld_buf_full_o;
  logic        overflow_o;

  int total = 0;
  int bad   = 0;

  logic [36:0] wq[$];
  int          gq[$];
  logic [1:0]  cq[$];
  logic        fq[$];
  logic        ovq[$];

  fpu_ss_wb_arbiter_if wb_if ();

  fpu_ss_wb_arbiter #(
    .LD_BUF_DEPTH (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .wb            (wb_if),
    .fpr_we_o      (fpr_we_o),
    .fpr_waddr_o   (fpr_waddr_o),
    .fpr_wdata_o   (fpr_wdata_o),
    .ld_buf_cnt_o  (ld_buf_cnt_o),
    .ld_buf_full_o (ld_buf_full_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Load k -> addr k, data 0x4000_0000+k; FPU result n -> addr 20+n, data 0xF000_0000+n.
  function automatic logic [36:0] exp_wb(input int code);
    if (code > 0) return {5'(code), 32'h4000_0000 + 32'(code)};
    return {5'(20 - code), 32'hF000_0000 + 32'(-code)};
  endfunction

  // One clock: apply inputs, sample combinational outputs, then log any FPR write.
  task automatic cycle(input logic ld_v, input logic [4:0] ld_a, input logic [31:0] ld_d,
                       input logic f_v, input logic f_fpr, input logic [4:0] f_a,
                       input logic [31:0] f_d, input logic iw_rdy,
                       output logic rdy, output logic ivalid,
                       output logic [4:0] iaddr, output logic [31:0] idata);
    wb_if.mem_result_valid_i = ld_v;
    wb_if.mem_waddr_i        = ld_a;
    wb_if.mem_result_i       = ld_d;
    wb_if.fpu_out_valid_i    = f_v;
    wb_if.fpu_rd_is_fpr_i    = f_fpr;
    wb_if.fpu_waddr_i        = f_a;
    wb_if.fpu_result_i       = f_d;
    wb_if.int_wb_ready_i     = iw_rdy;
    #1;
    rdy    = wb_if.fpu_out_ready_o;
    ivalid = wb_if.int_wb_valid_o;
    iaddr  = wb_if.int_wb_addr_o;
    idata  = wb_if.int_wb_data_o;
    @(posedge clk_i);
    #1;
    if (fpr_we_o === 1'b1) begin
      wq.push_back({fpr_waddr_o, fpr_wdata_o});
      $display("fpr write addr=%0d data=%08h cnt=%0d", fpr_waddr_o, fpr_wdata_o, ld_buf_cnt_o);
    end
  endtask

  task automatic idle(input int n);
    logic r, iv;
    logic [4:0] ia;
    logic [31:0] id;
    for (int i = 0; i < n; i++)
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, r, iv, ia, id);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle(1);
    rst_ni = 1'b1;
    wq.delete();
  endtask

  // Load k on every cycle k=1..n while FPU FPR results 1..n_fpu stay pending.
  task automatic stream(input int n, input int n_fpu);
    logic r, iv;
    logic [4:0] ia;
    logic [31:0] id;
    int f = 1;
    gq.delete(); cq.delete(); fq.delete(); ovq.delete();
    for (int c = 1; c <= n; c++) begin
      cycle(1'b1, 5'(c), 32'h4000_0000 + 32'(c), (f <= n_fpu), 1'b1, 5'(20 + f),
            32'hF000_0000 + 32'(f), 1'b0, r, iv, ia, id);
      if (r && f <= n_fpu) begin
        gq.push_back(c);
        f++;
      end
      cq.push_back(ld_buf_cnt_o);
      fq.push_back(ld_buf_full_o);
      ovq.push_back(overflow_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (fpr_we_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", fpr_we_o); end
    total++; if (fpr_waddr_o !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", fpr_waddr_o); end
    total++; if (fpr_wdata_o !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%08h exp=0", fpr_wdata_o); end
    total++; if (ld_buf_cnt_o !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", ld_buf_cnt_o); end
    total++; if (ld_buf_full_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", ld_buf_full_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
  endtask

  task automatic test_single_fadd();
    logic r, iv;
    logic [4:0] ia;
    logic [31:0] id;
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd3, 32'h3F80_0000, 1'b0, r, iv, ia, id);
    total++; if (r !== 1'b1) begin bad++; $display("FAIL fadd_ready got=%b exp=1", r); end
    total++; if (iv !== 1'b0) begin bad++; $display("FAIL fadd_intvalid got=%b exp=0", iv); end
    total++; if (fpr_we_o !== 1'b1) begin bad++; $display("FAIL fadd_we got=%b exp=1", fpr_we_o); end
    total++; if (fpr_waddr_o !== 5'd3) begin bad++; $display("FAIL fadd_waddr got=%0d exp=3", fpr_waddr_o); end
    total++; if (fpr_wdata_o !== 32'h3F80_0000) begin bad++; $display("FAIL fadd_wdata got=%08h exp=3f800000", fpr_wdata_o); end
    idle(1);
    total++; if (fpr_we_o !== 1'b0) begin bad++; $display("FAIL fadd_we_after got=%b exp=0", fpr_we_o); end
  endtask

  task automatic test_load_vs_fpu();
    logic r, iv;
    logic [4:0] ia;
    logic [31:0] id;
    cycle(1'b1, 5'd5, 32'h4000_0000, 1'b1, 1'b1, 5'd6, 32'h4040_0000, 1'b0, r, iv, ia, id);
    total++; if (r !== 1'b0) begin bad++; $display("FAIL lvf_ready1 got=%b exp=0", r); end
    total++; if ({fpr_we_o, fpr_waddr_o, fpr_wdata_o} !== {1'b1, 5'd5, 32'h4000_0000}) begin
      bad++; $display("FAIL lvf_load_write got=%b/%0d/%08h exp=1/5/40000000", fpr_we_o, fpr_waddr_o, fpr_wdata_o);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd6, 32'h4040_0000, 1'b0, r, iv, ia, id);
    total++; if (r !== 1'b1) begin bad++; $display("FAIL lvf_ready2 got=%b exp=1", r); end
    total++; if ({fpr_we_o, fpr_waddr_o, fpr_wdata_o} !== {1'b1, 5'd6, 32'h4040_0000}) begin
      bad++; $display("FAIL lvf_fpu_write got=%b/%0d/%08h exp=1/6/40400000", fpr_we_o, fpr_waddr_o, fpr_wdata_o);
    end
    total++; if (ld_buf_cnt_o !== 2'd0) begin bad++; $display("FAIL lvf_cnt got=%0d exp=0", ld_buf_cnt_o); end
    idle(1);
  endtask

  task automatic test_starvation();
    int exp3[7] = '{1, 2, 3, 4, -1, 5, 6};
    do_reset();
    stream(6, 1);
    total++; if (gq.size() != 1 || gq[0] != 5) begin
      bad++; $display("FAIL starve_grant got_n=%0d first=%0d exp=1x cycle5", gq.size(), (gq.size() > 0) ? gq[0] : -1);
    end
    total++; if (cq[4] !== 2'd1) begin bad++; $display("FAIL starve_cnt_c5 got=%0d exp=1", cq[4]); end
    total++; if (cq[5] !== 2'd1) begin bad++; $display("FAIL starve_cnt_c6 got=%0d exp=1", cq[5]); end
    idle(2);
    total++; if (ld_buf_cnt_o !== 2'd0) begin bad++; $display("FAIL starve_drain_cnt got=%0d exp=0", ld_buf_cnt_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL starve_ovf got=%b exp=0", overflow_o); end
    total++; if (wq.size() != 7) begin bad++; $display("FAIL starve_nwrites got=%0d exp=7", wq.size()); end
    for (int i = 0; i < 7 && i < wq.size(); i++) begin
      total++; if (wq[i] !== exp_wb(exp3[i])) begin
        bad++; $display("FAIL starve_order[%0d] got=%010h exp=%010h", i, wq[i], exp_wb(exp3[i]));
      end
    end
  endtask

  task automatic test_overflow();
    int exp4[17] = '{1, 2, 3, 4, -1, 5, 6, 7, 8, -2, 9, 10, 11, 12, -3, 13, 14};
    do_reset();
    stream(15, 3);
    total++; if (gq.size() != 3 || gq[0] != 5 || gq[1] != 10 || gq[2] != 15) begin
      bad++; $display("FAIL ovf_grants got_n=%0d exp=3 at 5/10/15", gq.size());
    end
    total++; if (cq[9] !== 2'd2 || fq[9] !== 1'b1) begin
      bad++; $display("FAIL ovf_full_c10 got=%0d/%b exp=2/1", cq[9], fq[9]);
    end
    total++; if (ovq[13] !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovq[13]); end
    total++; if (ovq[14] !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovq[14]); end
    idle(3);
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
    total++; if (ld_buf_cnt_o !== 2'd0) begin bad++; $display("FAIL ovf_drain_cnt got=%0d exp=0", ld_buf_cnt_o); end
    total++; if (wq.size() != 17) begin bad++; $display("FAIL ovf_nwrites got=%0d exp=17", wq.size()); end
    for (int i = 0; i < 17 && i < wq.size(); i++) begin
      total++; if (wq[i] !== exp_wb(exp4[i])) begin
        bad++; $display("FAIL ovf_order[%0d] got=%010h exp=%010h", i, wq[i], exp_wb(exp4[i]));
      end
    end
  endtask

  task automatic test_int_handshake();
    logic r, iv;
    logic [4:0] ia;
    logic [31:0] id;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd10, 32'd1, 1'b0, r, iv, ia, id);
      total++; if (iv !== 1'b1 || r !== 1'b0) begin
        bad++; $display("FAIL feq_wait[%0d] got valid=%b ready=%b exp valid=1 ready=0", i, iv, r);
      end
      total++; if (ia !== 5'd10 || id !== 32'd1) begin
        bad++; $display("FAIL feq_payload[%0d] got=%0d/%0h exp=10/1", i, ia, id);
      end
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd10, 32'd1, 1'b1, r, iv, ia, id);
    total++; if (iv !== 1'b1 || r !== 1'b1) begin
      bad++; $display("FAIL feq_hs got valid=%b ready=%b exp 1/1", iv, r);
    end
    idle(1);
    total++; if (wq.size() != 0) begin bad++; $display("FAIL feq_no_fpr got=%0d exp=0", wq.size()); end
    rst_ni = 1'b0;
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd7, 32'd0, 1'b1, r, iv, ia, id);
    rst_ni = 1'b1;
    total++; if (iv !== 1'b1 || r !== 1'b1) begin
      bad++; $display("FAIL int_in_reset got valid=%b ready=%b exp 1/1", iv, r);
    end
    idle(1);
  endtask

  task automatic test_reset_midop();
    do_reset();
    stream(15, 3);
    total++; if (cq[14] !== 2'd2 || ovq[14] !== 1'b1) begin
      bad++; $display("FAIL rst_setup got cnt=%0d ovf=%b exp 2/1", cq[14], ovq[14]);
    end
    do_reset();
    total++; if (ld_buf_cnt_o !== 2'd0 || ld_buf_full_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid_cnt got=%0d/%b exp=0/0", ld_buf_cnt_o, ld_buf_full_o);
    end
    total++; if (fpr_we_o !== 1'b0) begin bad++; $display("FAIL rst_mid_we got=%b exp=0", fpr_we_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL rst_mid_ovf got=%b exp=0", overflow_o); end
    idle(3);
    total++; if (wq.size() != 0) begin bad++; $display("FAIL rst_mid_nowrite got=%0d exp=0", wq.size()); end
  endtask

  initial begin
    wb_if.fpu_out_valid_i    = 1'b0;
    wb_if.fpu_rd_is_fpr_i    = 1'b0;
    wb_if.fpu_waddr_i        = '0;
    wb_if.fpu_result_i       = '0;
    wb_if.mem_result_valid_i = 1'b0;
    wb_if.mem_waddr_i        = '0;
    wb_if.mem_result_i       = '0;
    wb_if.int_wb_ready_i     = 1'b0;
    @(posedge clk_i);
    #1;
    test_reset();
    test_single_fadd();
    test_load_vs_fpu();
    test_starvation();
    test_overflow();
    test_int_handshake();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
